frame_capture_sequencer: RTL and testbench

- Sequences camera exposure and histogram capture for a burst of frames.
- Drives the sensor FSIN trigger at a fixed period and waits for each resulting MIPI frame (frame_valid).
- Gates the histogram engine to whole frames only, waits for its SPI drain, then retriggers.
- Sits between the MIPI-to-CMOS bridge, the histogram module and the FSIN pin, all in the clk_pixel_hs domain.

---
 rtl/frame_capture_sequencer.sv | 162 ++++++++++++++++
 tb/tb_frame_capture_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_sequencer.sv
// Paces sensor FSIN triggers and gates the histogram engine to whole MIPI frames.
// Define CAPTURE_SKIP_FIRST_EN to discard the first frame after every accepted start.
module frame_capture_sequencer #(
  parameter int FSIN_PERIOD  = 3320000,
  parameter int FSIN_PULSE_W = 16,
  parameter int FV_TIMEOUT   = 4000000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [7:0] num_frames_i,
  input  logic       frame_valid_i,
  input  logic       hist_busy_i,
  output logic       fsin_o,
  output logic       hist_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic       overrun_o,
  output logic [7:0] frame_cnt_o
);

  typedef enum logic [2:0] {IDLE, TRIG, ARM, WAIT_FV, CAPTURE, DRAIN, GAP} state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(FSIN_PULSE_W - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(FSIN_PERIOD - 1);
  localparam logic [CNT_W-1:0] OVR_THR     = CNT_W'(FSIN_PERIOD - 2);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(FV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] elapsed;
  logic [7:0]       num_frames_q;
  logic             fv_q, stop_pend, skip_q, skip_nxt;
  logic             rise, fall, tmo_hit, burst_done;
  logic             accept, frame_inc, pend_set, done_nxt, set_tmo, set_ovr;

  assign rise       = frame_valid_i & ~fv_q;
  assign fall       = ~frame_valid_i & fv_q;
  assign tmo_hit    = (elapsed == TMO_LAST);
  assign burst_done = (num_frames_q != 8'd0) && (frame_cnt_o == num_frames_q) && !skip_q;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    frame_inc = 1'b0;
    pend_set  = 1'b0;
    done_nxt  = 1'b0;
    set_tmo   = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !stop_i) begin
          accept    = 1'b1;
          state_nxt = TRIG;
        end
      end
      TRIG: begin
        if (stop_i)                    state_nxt = IDLE;
        else if (elapsed >= PULSE_LAST) state_nxt = ARM;
      end
      // Never arm on a frame that is already in flight.
      ARM: begin
        if (stop_i) state_nxt = IDLE;
        else if (tmo_hit) begin
          set_tmo   = 1'b1;
          state_nxt = IDLE;
        end else if (!frame_valid_i) state_nxt = WAIT_FV;
      end
      WAIT_FV: begin
        if (stop_i) state_nxt = IDLE;
        else if (tmo_hit) begin
          set_tmo   = 1'b1;
          state_nxt = IDLE;
        end else if (rise) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        pend_set = stop_i;
        if (fall) begin
          frame_inc = !skip_q;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        pend_set = stop_i;
        if (!hist_busy_i) begin
          if (burst_done || stop_pend || stop_i) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            // GAP is entered one count later, so this flags a late frame on entry.
            set_ovr   = (elapsed >= OVR_THR);
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (stop_i || stop_pend) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (elapsed >= PERIOD_LAST) state_nxt = TRIG;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CAPTURE_SKIP_FIRST_EN
  always_comb begin
    skip_nxt = skip_q;
    if (accept) skip_nxt = 1'b1;
    else if (state_nxt == IDLE || (state == DRAIN && state_nxt != DRAIN)) skip_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) skip_q <= 1'b0;
    else            skip_q <= skip_nxt;
  end
`else
  assign skip_nxt = 1'b0;
  assign skip_q   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      elapsed      <= '0;
      num_frames_q <= 8'd0;
      fv_q         <= 1'b0;
      stop_pend    <= 1'b0;
      fsin_o       <= 1'b0;
      hist_en_o    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
      overrun_o    <= 1'b0;
      frame_cnt_o  <= 8'd0;
    end else begin
      state <= state_nxt;
      fv_q  <= frame_valid_i;
      // One elapsed counter serves both the FSIN period and the frame timeout.
      if (state_nxt == TRIG && state != TRIG) elapsed <= '0;
      else if (state == IDLE)                 elapsed <= '0;
      else if (elapsed != CNT_MAX)            elapsed <= elapsed + CNT_W'(1);
      if (accept) num_frames_q <= num_frames_i;
      if (accept)          frame_cnt_o <= 8'd0;
      else if (frame_inc)  frame_cnt_o <= frame_cnt_o + 8'd1;
      if (accept || state_nxt == IDLE) stop_pend <= 1'b0;
      else if (pend_set)               stop_pend <= 1'b1;
      if (accept)       timeout_o <= 1'b0;
      else if (set_tmo) timeout_o <= 1'b1;
      if (accept)       overrun_o <= 1'b0;
      else if (set_ovr) overrun_o <= 1'b1;
      fsin_o    <= (state_nxt == TRIG);
      hist_en_o <= (state_nxt == WAIT_FV || state_nxt == CAPTURE) && !skip_nxt;
      busy_o    <= (state_nxt != IDLE);
      done_o    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// Randomized bench for frame_capture_sequencer: a sensor/histogram emulator answers
// each FSIN pulse, and burst-level expectations are computed from the timing rules.
module tb_frame_capture_sequencer;

  localparam int P = 1000;
  localparam int W = 4;
  localparam int T = 500;
`ifdef CAPTURE_SKIP_FIRST_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] num_frames = 8'd0;
  logic       fv_sns = 1'b0;
  logic       fv_stray = 1'b0;
  logic       busy_sns = 1'b0;
  logic       fsin_o, hist_en_o, busy_o, done_o, timeout_o, overrun_o;
  logic [7:0] frame_cnt_o;
  logic       frame_valid;

  assign frame_valid = fv_sns | fv_stray;

  frame_capture_sequencer #(
    .FSIN_PERIOD (P),
    .FSIN_PULSE_W(W),
    .FV_TIMEOUT  (T),
    .CNT_W       (24)
  ) dut (
    .clk          (clk),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .stop_i       (stop),
    .num_frames_i (num_frames),
    .frame_valid_i(frame_valid),
    .hist_busy_i  (busy_sns),
    .fsin_o       (fsin_o),
    .hist_en_o    (hist_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .overrun_o    (overrun_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Event log gathered on the falling edge.
  int   rise_q[$];
  int   width_q[$];
  int   drop_q[$];
  int   w_run = 0;
  logic fsin_prev = 1'b0;
  int   n_done = 0;
  int   en_cov = 0;
  int   fv_cov = 0;
  int   stray_hits = 0;

  always @(negedge clk) begin
    if (fsin_o && !fsin_prev) rise_q.push_back(cyc);
    if (fsin_o) w_run <= w_run + 1;
    else if (w_run != 0) begin
      width_q.push_back(w_run);
      w_run <= 0;
    end
    fsin_prev <= fsin_o;
    if (done_o) n_done <= n_done + 1;
    if (fv_sns && hist_en_o) en_cov <= en_cov + 1;
    if (fv_sns && busy_o) fv_cov <= fv_cov + 1;
    if (fv_stray && hist_en_o) stray_hits <= stray_hits + 1;
  end

  // Sensor + histogram emulator: frame after each FSIN rise, then an SPI drain.
  logic sns_en = 1'b1;
  int   sns_dly = 50;
  int   sns_len = 100;
  int   sns_busy = 20;

  initial begin : sensor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fsin_o && !prev && sns_en) begin
        prev = 1'b1;
        repeat (sns_dly) @(posedge clk);
        #1 fv_sns = 1'b1;
        repeat (sns_len) @(posedge clk);
        #1 fv_sns = 1'b0;
        busy_sns = 1'b1;
        repeat (sns_busy) @(posedge clk);
        #1 busy_sns = 1'b0;
        drop_q.push_back(cyc);
      end else prev = fsin_o;
    end
  end

  task automatic pulse_start(input logic [7:0] n, output int s);
    @(posedge clk);
    #1 start = 1'b1;
    num_frames = n;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    num_frames = 8'($urandom);
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_idle"}, int'(busy_o), 0);
    #1;
  endtask

  task automatic wait_fv(input int budget, input string tag);
    int k = 0;
    while (!fv_sns && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_fv_seen"}, int'(fv_sns), 1);
  endtask

  task automatic wait_quiet();
    int k = 0;
    while ((fv_sns || busy_sns) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("sensor_quiet", int'(fv_sns | busy_sns), 0);
  endtask

  task automatic run_burst(input int n, input int dly, input int len, input int bsy,
                           input string tag);
    int s, b_rise, b_w, b_done, b_en, b_fv, bad_w, bad_p;
    sns_en = 1'b1;
    sns_dly = dly;
    sns_len = len;
    sns_busy = bsy;
    b_rise = rise_q.size();
    b_w = width_q.size();
    b_done = n_done;
    b_en = en_cov;
    b_fv = fv_cov;
    pulse_start(n[7:0], s);
    @(negedge clk);
    check_eq({tag, "_fsin_lat"}, int'(fsin_o), 1);
    check_eq({tag, "_flags_clr"}, int'({timeout_o, overrun_o}), 0);
    wait_idle((n + SKIP + 2) * P + 2000, tag);
    bad_w = 0;
    bad_p = 0;
    for (int i = b_w; i < width_q.size(); i++) if (width_q[i] != W) bad_w++;
    for (int i = b_rise + 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] != P) bad_p++;
    check_eq({tag, "_pulses"}, rise_q.size() - b_rise, n + SKIP);
    check_eq({tag, "_bad_width"}, bad_w, 0);
    check_eq({tag, "_bad_period"}, bad_p, 0);
    check_eq({tag, "_frame_cnt"}, int'(frame_cnt_o), n);
    check_eq({tag, "_done"}, n_done - b_done, 1);
    check_eq({tag, "_flags"}, int'({timeout_o, overrun_o}), 0);
    check_eq({tag, "_fv_seen_cyc"}, fv_cov - b_fv, (n + SKIP) * len);
    check_eq({tag, "_en_cov"}, en_cov - b_en, n * len);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
    $fatal(1);
  end

  initial begin : main
    int s, b_done, b_en, b_rise, b_drop, b_stray, n, k;

    repeat (3) @(negedge clk);
    check_eq("rst_outputs", int'({fsin_o, hist_en_o, busy_o, done_o, timeout_o, overrun_o,
                                  frame_cnt_o}), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_outputs", int'({fsin_o, hist_en_o, busy_o, done_o, timeout_o,
                                       overrun_o, frame_cnt_o}), 0);

    run_burst(3, 50, 100, 20, "basic");
    for (int i = 0; i < 3; i++)
      run_burst($urandom_range(1, 4), $urandom_range(20, 80), $urandom_range(50, 200),
                $urandom_range(5, 40), "rand_burst");

    // start together with stop must be ignored
    @(posedge clk);
    #1 start = 1'b1;
    stop = 1'b1;
    num_frames = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check_eq("start_stop_ignored", int'({busy_o, fsin_o}), 0);

    // no frame ever arrives
    sns_en = 1'b0;
    b_done = n_done;
    pulse_start(8'd1, s);
    @(negedge clk);
    check_eq("tmo_fsin", int'(fsin_o), 1);
    repeat (T - 1) @(negedge clk);
    check_eq("tmo_before", int'({timeout_o, busy_o}), 1);
    @(negedge clk);
    check_eq("tmo_flag", int'(timeout_o), 1);
    check_eq("tmo_busy", int'(busy_o), 0);
    #1;
    check_eq("tmo_no_done", n_done - b_done, 0);
    run_burst(1, 40, 80, 10, "tmo_restart");

    // frame already in progress when start arrives
    b_stray = stray_hits;
    @(posedge clk);
    #1 fv_stray = 1'b1;
    fork
      begin
        repeat (300) @(posedge clk);
        #1 fv_stray = 1'b0;
      end
    join_none
    repeat (19) @(posedge clk);
    run_burst(1, $urandom_range(330, 370), $urandom_range(50, 100), 10, "guard");
    check_eq("guard_stray_en", stray_hits - b_stray, 0);

    // stop while waiting for the frame
    sns_en = 1'b1;
    sns_dly = 100;
    sns_len = 100;
    sns_busy = 20;
    b_done = n_done;
    pulse_start(8'd2, s);
    repeat (30) @(negedge clk);
    check_eq("stopA_wait_en", int'(hist_en_o), 1 - SKIP);
    pulse_stop();
    @(negedge clk);
    check_eq("stopA_idle", int'({busy_o, fsin_o, hist_en_o}), 0);
    repeat (300) @(negedge clk);
    #1;
    check_eq("stopA_no_done", n_done - b_done, 0);
    check_eq("stopA_frame_cnt", int'(frame_cnt_o), 0);

    // stop mid-frame: the frame completes and drains
    sns_dly = $urandom_range(20, 80);
    sns_len = $urandom_range(50, 150);
    sns_busy = $urandom_range(5, 30);
    n = $urandom_range(2, 5);
    b_done = n_done;
    b_en = en_cov;
    b_rise = rise_q.size();
    pulse_start(n[7:0], s);
    wait_fv(2000, "stopB");
    repeat (5) @(negedge clk);
    pulse_stop();
    wait_idle(3000, "stopB");
    check_eq("stopB_done", n_done - b_done, 1);
    check_eq("stopB_frame_cnt", int'(frame_cnt_o), 1 - SKIP);
    check_eq("stopB_pulses", rise_q.size() - b_rise, 1);
    check_eq("stopB_en_cov", en_cov - b_en, (1 - SKIP) * sns_len);

    // drain longer than the FSIN period
    sns_dly = 50;
    sns_len = 100;
    sns_busy = 1200;
    b_done = n_done;
    b_rise = rise_q.size();
    b_drop = drop_q.size();
    pulse_start(8'd2, s);
    wait_idle((3 + SKIP) * 1500, "ovr");
    check_eq("ovr_flag", int'(overrun_o), 1);
    check_eq("ovr_pulses", rise_q.size() - b_rise, 2 + SKIP);
    check_eq("ovr_refire",
             (rise_q.size() > b_rise + 1 && drop_q.size() > b_drop) ?
               rise_q[b_rise+1] - drop_q[b_drop] : -1, 2);
    check_eq("ovr_frame_cnt", int'(frame_cnt_o), 2);
    check_eq("ovr_done", n_done - b_done, 1);

    // continuous mode, stop during the inter-frame gap
    sns_dly = 30;
    sns_len = 50;
    sns_busy = 10;
    b_drop = drop_q.size();
    pulse_start(8'd0, s);
    k = 0;
    while (drop_q.size() < b_drop + 2 + SKIP && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_eq("gap_frames_seen", drop_q.size() - b_drop, 2 + SKIP);
    repeat (20) @(negedge clk);
    check_eq("gap_busy", int'(busy_o), 1);
    pulse_stop();
    @(negedge clk);
    check_eq("gap_stop_done", int'(done_o), 1);
    check_eq("gap_stop_idle", int'(busy_o), 0);
    check_eq("gap_frame_cnt", int'(frame_cnt_o), 2);

    // asynchronous reset mid-capture
    sns_dly = 50;
    sns_len = 100;
    sns_busy = 20;
    pulse_start(8'd2, s);
    wait_fv(2000, "arst");
    repeat (10) @(negedge clk);
    check_eq("arst_busy_before", int'(busy_o), 1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("arst_outputs", int'({fsin_o, hist_en_o, busy_o, done_o, timeout_o, overrun_o,
                                   frame_cnt_o}), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_quiet();
    run_burst(1, $urandom_range(20, 80), $urandom_range(50, 150), $urandom_range(5, 30),
              "arst_restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
